// File: rtl/tlk2711_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tlk2711_rd_arb
// Brief    : Round-robin arbiter sharing the tlk2711_dma read-command and
//            read-stream channel between NUM_REQ requesters. One grant is
//            held from command issue until the last stream beat is accepted;
//            a stalled transfer is aborted after TIMEOUT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tlk2711_rd_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DLEN_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 65535
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_soft_rst,
  input  logic [NUM_REQ-1:0]                         i_req,
  input  logic [NUM_REQ*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_cmd_data,
  output logic [NUM_REQ-1:0]                         o_ack,
  output logic                                       o_rd_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]           o_rd_cmd_data,
  input  logic                                       i_rd_cmd_ack,
  input  logic                                       i_dma_rd_valid,
  input  logic                                       i_dma_rd_last,
  input  logic [DATA_WIDTH-1:0]                      i_dma_rd_data,
  output logic                                       o_dma_rd_ready,
  output logic [NUM_REQ-1:0]                         o_rd_valid,
  output logic                                       o_rd_last,
  output logic [DATA_WIDTH-1:0]                      o_rd_data,
  input  logic [NUM_REQ-1:0]                         i_rd_ready,
  output logic [NUM_REQ-1:0]                         o_grant,
  output logic                                       o_busy,
  output logic                                       o_timeout
);

  localparam int             c_cmd_w    = DLEN_WIDTH + ADDR_WIDTH;
  localparam int             c_idx_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
  // Counter value in the cycle that completes TIMEOUT idle cycles
  localparam logic [15:0]    c_cnt_last = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_REQ-1:0]   r_grant;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   r_ptr;
  logic [15:0]          r_cnt;
  logic                 r_timeout;
  logic [c_cmd_w-1:0]   r_cmd;

  logic                 w_found;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [c_cmd_w-1:0]   w_pick_cmd;
  logic                 w_ready;
  logic                 w_beat;
  logic                 w_cmd_ack;
  logic                 w_done;
  logic                 w_expire;
  logic                 w_abort;

  // Round-robin search: first requesting index at or above r_ptr, wrapping
  always_comb begin
    int j;
    j          = 0;
    w_found    = 1'b0;
    w_pick_idx = '0;
    w_pick_oh  = '0;
    w_pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && i_req[j]) begin
        w_found      = 1'b1;
        w_pick_idx   = c_idx_w'(j);
        w_pick_oh[j] = 1'b1;
        w_pick_cmd   = i_cmd_data[j*c_cmd_w +: c_cmd_w];
      end
    end
  end

  assign w_ready   = |(i_rd_ready & r_grant);
  assign w_beat    = (r_state == S_XFER) && i_dma_rd_valid && w_ready;
  assign w_cmd_ack = (r_state == S_ISSUE) && i_rd_cmd_ack;
  assign w_done    = w_beat && i_dma_rd_last;
  assign w_expire  = (r_cnt == c_cnt_last);
  // An ack or an accepted beat in the expiry cycle takes precedence
  assign w_abort   = (r_state != S_IDLE) && w_expire && !w_cmd_ack && !w_beat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_state <= S_IDLE;
    else if (i_soft_rst) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  // Next-state logic and channel steering toward DMA and requesters
  always_comb begin
    w_next         = r_state;
    o_rd_cmd_req   = 1'b0;
    o_ack          = '0;
    o_dma_rd_ready = 1'b0;
    o_rd_valid     = '0;
    o_rd_last      = 1'b0;
    o_rd_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        o_rd_cmd_req = 1'b1;
        if (w_cmd_ack) begin
          o_ack  = r_grant;
          w_next = S_XFER;
        end else if (w_abort) begin
          w_next = S_IDLE;
        end
      end
      S_XFER: begin
        o_dma_rd_ready = w_ready;
        o_rd_valid     = r_grant & {NUM_REQ{i_dma_rd_valid}};
        o_rd_last      = i_dma_rd_last;
        o_rd_data      = i_dma_rd_data;
        if (w_done || w_abort) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant, latched command and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cmd   <= '0;
    end else if (i_soft_rst) begin
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cmd   <= '0;
    end else if ((r_state == S_IDLE) && w_found) begin
      r_grant <= w_pick_oh;
      r_idx   <= w_pick_idx;
      r_cmd   <= w_pick_cmd;
    end else if (w_done || w_abort) begin
      r_grant <= '0;
      r_ptr   <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
    end
  end

  // Stall watchdog: cleared while idle, on command ack and on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_cnt <= '0;
    else if (i_soft_rst)                               r_cnt <= '0;
    else if ((r_state == S_IDLE) || w_cmd_ack || w_beat) r_cnt <= '0;
    else if (!w_expire)                                r_cnt <= r_cnt + 16'd1;
  end

  // Sticky abort flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_timeout <= 1'b0;
    else if (i_soft_rst) r_timeout <= 1'b0;
    else if (w_abort)    r_timeout <= 1'b1;
  end

  assign o_rd_cmd_data = r_cmd;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlk2711_rd_arb
// Brief    : Self-checking bench for tlk2711_rd_arb with a beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlk2711_rd_arb;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_soft_rst = 1'b0;
  logic [NR-1:0]   i_req = '0;
  logic [NR*64-1:0] i_cmd_data = '0;
  logic [NR-1:0]   o_ack;
  logic            o_rd_cmd_req;
  logic [63:0]     o_rd_cmd_data;
  logic            i_rd_cmd_ack = 1'b0;
  logic            i_dma_rd_valid = 1'b0;
  logic            i_dma_rd_last = 1'b0;
  logic [63:0]     i_dma_rd_data = '0;
  logic            o_dma_rd_ready;
  logic [NR-1:0]   o_rd_valid;
  logic            o_rd_last;
  logic [63:0]     o_rd_data;
  logic [NR-1:0]   i_rd_ready = '1;
  logic [NR-1:0]   o_grant;
  logic            o_busy;
  logic            o_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  tlk2711_rd_arb #(
    .NUM_REQ(NR), .ADDR_WIDTH(48), .DLEN_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst), .i_req(i_req),
    .i_cmd_data(i_cmd_data), .o_ack(o_ack), .o_rd_cmd_req(o_rd_cmd_req),
    .o_rd_cmd_data(o_rd_cmd_data), .i_rd_cmd_ack(i_rd_cmd_ack),
    .i_dma_rd_valid(i_dma_rd_valid), .i_dma_rd_last(i_dma_rd_last),
    .i_dma_rd_data(i_dma_rd_data), .o_dma_rd_ready(o_dma_rd_ready),
    .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last), .o_rd_data(o_rd_data),
    .i_rd_ready(i_rd_ready), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [47:0] addr, input int b);
    return {16'(b) ^ 16'h5A00, addr};
  endfunction

  task automatic set_cmd(input int k, input logic [15:0] len, input logic [47:0] addr);
    i_cmd_data[k*64 +: 64] = {len, addr};
  endtask

  // Scoreboard producer: expected beats for a command of n beats
  task automatic push_exp(input int idx, input logic [47:0] addr, input int n);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.idx  = idx;
      e.data = pat(addr, b);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Wait for the command toward the DMA, check it, then accept it
  task automatic issue(input int idx, input logic [63:0] cmd);
    int c = 0;
    logic [NR-1:0] m;
    m = NR'(1 << idx);
    @(negedge clk);
    while (!o_rd_cmd_req && c < 20) begin
      @(posedge clk); #1; @(negedge clk); c++;
    end
    n_tests++;
    if (o_rd_cmd_req !== 1'b1 || o_grant !== m || o_rd_cmd_data !== cmd) begin
      n_fail++;
      $display("FAIL issue[%0d]: req=%b grant=%b cmd=%h, want req=1 grant=%b cmd=%h",
               idx, o_rd_cmd_req, o_grant, o_rd_cmd_data, m, cmd);
    end
    @(posedge clk); #1; i_rd_cmd_ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_ack !== m) begin
      n_fail++;
      $display("FAIL ack[%0d]: got %b want %b", idx, o_ack, m);
    end
    @(posedge clk); #1; i_rd_cmd_ack = 1'b0;
  endtask

  // DMA stream model plus scoreboard consumer
  task automatic serve(input int idx, input logic [47:0] addr, input int nb,
                       input int st_at, input int st_len, input int gap, input int stop);
    int b = 0, st_done = 0, g_done = 0, cyc = 0;
    logic stall, vld;
    logic [NR-1:0] m;
    beat_t e;
    m = NR'(1 << idx);
    while (b < nb && b < stop && cyc < 400) begin
      stall = (b == st_at) && (st_done < st_len);
      if (stall) st_done++;
      vld = !((b == nb - 1) && (g_done < gap));
      if (!vld) g_done++;
      i_rd_ready     = stall ? ~m : '1;
      i_dma_rd_valid = vld;
      i_dma_rd_last  = (b == nb - 1);
      i_dma_rd_data  = pat(addr, b);
      @(negedge clk);
      n_tests++;
      if (o_rd_valid !== (vld ? m : '0)) begin
        n_fail++;
        $display("FAIL rd_valid beat %0d: got %b want %b", b, o_rd_valid, vld ? m : '0);
      end
      n_tests++;
      if (o_dma_rd_ready !== !stall) begin
        n_fail++;
        $display("FAIL dma_rd_ready beat %0d: got %b want %b", b, o_dma_rd_ready, !stall);
      end
      if (vld && !stall) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: beat %0d on req %0d with nothing expected", b, idx);
        end else begin
          e = exp_q.pop_front();
          if (e.idx != idx || o_rd_data !== e.data || o_rd_last !== e.last) begin
            n_fail++;
            $display("FAIL beat %0d: req=%0d data=%h last=%b, want req=%0d data=%h last=%b",
                     b, idx, o_rd_data, o_rd_last, e.idx, e.data, e.last);
          end
        end
      end
      @(posedge clk); #1;
      if (vld && !stall) b++;
      cyc++;
    end
    i_dma_rd_valid = 1'b0;
    i_dma_rd_last  = 1'b0;
    i_rd_ready     = '1;
    if (cyc >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL serve bound: %0d beats of %0d after %0d cycles", b, nb, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({o_ack, o_rd_cmd_req, o_rd_cmd_data, o_dma_rd_ready, o_rd_valid, o_rd_last,
         o_rd_data, o_grant, o_busy, o_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: grant=%b busy=%b req=%b want all 0", o_grant, o_busy, o_rd_cmd_req);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_cmd(2, 16'h0100, 48'h1000);
    i_req = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (o_rd_cmd_req !== 1'b0) begin
      n_fail++; $display("FAIL single early req: got %b want 0", o_rd_cmd_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (o_rd_cmd_req !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL single latency: req=%b busy=%b want 1 1", o_rd_cmd_req, o_busy);
    end
    @(posedge clk); #1;
    issue(2, {16'h0100, 48'h1000});
    i_req = '0;
    push_exp(2, 48'h1000, 32);
    serve(2, 48'h1000, 32, -1, 0, 0, 1000);
    @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b0 || o_grant !== '0) begin
      n_fail++; $display("FAIL single idle: busy=%b grant=%b want 0 0", o_busy, o_grant);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    i_soft_rst = 1'b1;
    @(posedge clk); #1 i_soft_rst = 1'b0;
    for (int k = 0; k < NR; k++) set_cmd(k, 16'h0020, 48'h2000 + 48'(k * 256));
    i_req = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      issue(t % NR, {16'h0020, 48'h2000 + 48'((t % NR) * 256)});
      if (t == 11) i_req = '0;
      push_exp(t % NR, 48'h2000 + 48'((t % NR) * 256), 4);
      serve(t % NR, 48'h2000 + 48'((t % NR) * 256), 4, -1, 0, 0, 1000);
    end
  endtask

  task automatic test_backpressure();
    set_cmd(1, 16'h0040, 48'h3000);
    i_req = 4'b0010;
    issue(1, {16'h0040, 48'h3000});
    i_req = '0;
    push_exp(1, 48'h3000, 8);
    serve(1, 48'h3000, 8, 3, 5, 0, 1000);
  endtask

  task automatic test_timeout();
    int c;
    c = 0;
    set_cmd(2, 16'h0040, 48'h4000);
    set_cmd(3, 16'h0010, 48'h5000);
    i_req = 4'b1100;
    issue(2, {16'h0040, 48'h4000});
    @(negedge clk);
    c = 1;
    while (!o_timeout && c < 40) begin
      @(posedge clk); #1; @(negedge clk); c++;
    end
    n_tests++;
    if (o_timeout !== 1'b1 || (c - 1) != 16) begin
      n_fail++; $display("FAIL timeout delay: flag=%b after %0d cycles, want 1 after 16", o_timeout, c - 1);
    end
    n_tests++;
    if (o_busy !== 1'b0 || o_grant !== '0 || o_dma_rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout idle: busy=%b grant=%b ready=%b want 0", o_busy, o_grant, o_dma_rd_ready);
    end
    @(posedge clk); #1;
    issue(3, {16'h0010, 48'h5000});
    i_req = '0;
    push_exp(3, 48'h5000, 2);
    serve(3, 48'h5000, 2, -1, 0, 0, 1000);
    @(negedge clk);
    n_tests++;
    if (o_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout sticky: got %b want 1", o_timeout);
    end
    @(posedge clk); #1 i_soft_rst = 1'b1;
    @(posedge clk); #1 i_soft_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout clear: got %b want 0", o_timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    set_cmd(0, 16'h0010, 48'h6000);
    set_cmd(2, 16'h0040, 48'h7000);
    i_req = 4'b0100;
    issue(2, {16'h0040, 48'h7000});
    i_req = '0;
    push_exp(2, 48'h7000, 8);
    serve(2, 48'h7000, 8, -1, 0, 0, 3);
    i_dma_rd_valid = 1'b1;
    i_dma_rd_data  = pat(48'h7000, 3);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_ack, o_rd_cmd_req, o_rd_cmd_data, o_dma_rd_ready, o_rd_valid, o_rd_last,
         o_rd_data, o_grant, o_busy, o_timeout} !== '0) begin
      n_fail++;
      $display("FAIL async reset: valid=%b ready=%b grant=%b busy=%b want all 0",
               o_rd_valid, o_dma_rd_ready, o_grant, o_busy);
    end
    exp_q.delete();
    i_dma_rd_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    i_req = 4'b0101;
    issue(0, {16'h0010, 48'h6000});
    i_req = 4'b0100;
    push_exp(0, 48'h6000, 2);
    serve(0, 48'h6000, 2, -1, 0, 0, 1000);
    issue(2, {16'h0040, 48'h7000});
    i_req = '0;
    push_exp(2, 48'h7000, 8);
    serve(2, 48'h7000, 8, -1, 0, 0, 1000);
  endtask

  task automatic test_last_at_timeout();
    set_cmd(1, 16'h0010, 48'h8000);
    i_req = 4'b0010;
    issue(1, {16'h0010, 48'h8000});
    i_req = '0;
    push_exp(1, 48'h8000, 2);
    serve(1, 48'h8000, 2, -1, 0, 15, 1000);
    @(negedge clk);
    n_tests++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL last vs timeout: timeout=%b busy=%b want 0 0", o_timeout, o_busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_async_reset();
    test_last_at_timeout();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard leftover: %0d beats never delivered, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
